// File: rtl/seg7_pkg.sv
// Shared types and display constants for the 7-segment display arbiter.
// Optional urgent-requester preemption is enabled by SEG7_ARB_PREEMPT_EN.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } arb_state_t;

    localparam int SEG7_NUM_W    = 32;
    localparam int SEG7_AN_NUM   = 8;
    localparam int SEG7_CATH_NUM = 7;

endpackage

// File: rtl/seg7_rr_picker.sv
// Rotating priority encoder: first requester found after ptr_i wins.
// Purely combinational; ptr_i itself has the lowest priority.
module seg7_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int IW = $clog2(N_REQ);

    int             j;
    logic [IW-1:0]  k;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        k       = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = (int'(ptr_i) + i) % N_REQ;
            k = IW'(j);
            if (req_i[k]) begin
                valid_o = 1'b1;
                idx_o   = k;
            end
        end
    end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin owner arbitration of the 8-digit display with a minimum dwell.
// Define SEG7_ARB_PREEMPT_EN to let requester 0 preempt other owners.
module seg7_disp_arbiter
    import seg7_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 1_000_000,
    parameter int NUM_W       = SEG7_NUM_W
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*NUM_W-1:0]   num_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     busy_o,
    output logic [NUM_W-1:0]         num_o,
    output logic                     seg_rst_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              srst_q, srst_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ever_q, ever_d;

    logic              pick_v;
    logic [IW-1:0]     pick_idx;
    logic              load_en;
    logic [IW-1:0]     load_idx;
    logic              follow;
    logic [NUM_W-1:0]  src [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign src[g] = num_i[g*NUM_W +: NUM_W];
    end

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    seg7_rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req_i  (req_i),
        .ptr_i  (rr_q),
        .valid_o(pick_v),
        .idx_o  (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        num_d    = num_q;
        srst_d   = srst_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        ever_d   = ever_q;
        load_en  = 1'b0;
        load_idx = pick_idx;
        follow   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                srst_d  = ~ever_q;
                load_en = pick_v;
            end
            LOAD: begin
                state_d = HOLD;
                cnt_d   = CNT_LOAD;
                srst_d  = 1'b0;
                follow  = 1'b1;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (!pick_v) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end else if (pick_idx != owner_q) begin
                        load_en = 1'b1;
                    end else begin
                        // Sole requester keeps the display without a blank.
                        cnt_d  = CNT_LOAD;
                        follow = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    follow = 1'b1;
                end
`ifdef SEG7_ARB_PREEMPT_EN
                if (req_i[0] && owner_q != '0) begin
                    load_en  = 1'b1;
                    load_idx = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (follow) begin
            gnt_d = req_i[owner_q] ? onehot(owner_q) : '0;
            if (req_i[owner_q])
                num_d = src[owner_q];
        end

        if (load_en) begin
            state_d = LOAD;
            gnt_d   = onehot(load_idx);
            owner_d = load_idx;
            num_d   = src[load_idx];
            srst_d  = 1'b1;
            busy_d  = 1'b1;
            rr_d    = load_idx;
            ever_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            num_q   <= '0;
            srst_q  <= 1'b1;
            rr_q    <= PTR_RST;
            cnt_q   <= '0;
            ever_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            num_q   <= num_d;
            srst_q  <= srst_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            ever_q  <= ever_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign busy_o    = busy_q;
    assign num_o     = num_q;
    assign seg_rst_o = srst_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Self-checking bench for seg7_disp_arbiter (N_REQ=4, HOLD_CYCLES=8).
// Preemption scenario is compiled in only with SEG7_ARB_PREEMPT_EN.
module tb_seg7_disp_arbiter;

    localparam int N = 4;
    localparam int H = 8;
    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] num_i = '0;
    logic [N-1:0]   gnt_o;
    logic [1:0]     owner_o;
    logic           busy_o;
    logic [W-1:0]   num_o;
    logic           seg_rst_o;

    int n_chk  = 0;
    int n_fail = 0;

    seg7_disp_arbiter #(
        .N_REQ      (N),
        .HOLD_CYCLES(H),
        .NUM_W      (W)
    ) dut (
        .clk_i    (clk_i),
        .rst      (rst),
        .req_i    (req_i),
        .num_i    (num_i),
        .gnt_o    (gnt_o),
        .owner_o  (owner_o),
        .busy_o   (busy_o),
        .num_o    (num_o),
        .seg_rst_o(seg_rst_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: phase 0 idle, 1 just granted, 2 dwelling
    int          m_ph, m_own, m_rr, m_el;
    bit          m_ever;
    logic [3:0]  m_gnt;
    logic        m_busy, m_srst;
    logic [31:0] m_num;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail < 20)
                $display("FAIL %s: got %h expected %h at %0t", name, got,
                         exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int after);
        for (int k = 1; k <= N; k++)
            if (r[(after + k) % N]) return (after + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_ph = 0; m_own = 0; m_rr = N - 1; m_el = 0; m_ever = 0;
        m_gnt = 0; m_busy = 0; m_srst = 1; m_num = 0;
    endtask

    task automatic m_grant(input int w, input logic [127:0] n);
        m_ph = 1; m_own = w; m_rr = w; m_ever = 1;
        m_gnt = 4'(1 << w); m_num = n[w*W +: W];
        m_srst = 1; m_busy = 1;
    endtask

    task automatic m_follow(input logic [3:0] r, input logic [127:0] n);
        if (r[m_own]) begin
            m_gnt = 4'(1 << m_own);
            m_num = n[m_own*W +: W];
        end else begin
            m_gnt = 0;
        end
    endtask

    task automatic m_step(input logic [3:0] r, input logic [127:0] n);
        int w;
        w = pick(r, m_rr);
        if (m_ph == 0) begin
            if (w >= 0) m_grant(w, n);
            else begin m_gnt = 0; m_busy = 0; m_srst = !m_ever; end
        end else if (m_ph == 1) begin
            m_ph = 2; m_el = 0; m_srst = 0;
            m_follow(r, n);
`ifdef SEG7_ARB_PREEMPT_EN
        end else if (m_own != 0 && r[0]) begin
            m_grant(0, n);
`endif
        end else if (m_el == H - 1) begin
            if (w < 0) begin m_ph = 0; m_gnt = 0; m_busy = 0; end
            else if (w != m_own) m_grant(w, n);
            else begin m_el = 0; m_follow(r, n); end
        end else begin
            m_el++;
            m_follow(r, n);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        m_step(req_i, num_i);
        chk("model", {24'h0, gnt_o, owner_o, busy_o, seg_rst_o, num_o},
            {24'h0, m_gnt, 2'(m_own), m_busy, m_srst, m_num});
        @(negedge clk_i);
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {24'h0, gnt_o, owner_o, busy_o, seg_rst_o, num_o},
            {24'h0, 4'b0000, 2'd0, 1'b0, 1'b1, 32'h0});
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst = 1'b1;
        req_i = '0;
        #1;
        chk_reset_vals("reset");
        m_reset();
        @(negedge clk_i);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   req;
        logic [127:0] num;
        logic [3:0]   gnt;
        logic [1:0]   own;
        logic         busy;
        logic         srst;
        logic [31:0]  numo;
    } vec_t;

    vec_t         tv [10];
    logic [127:0] nv;
    logic [31:0]  held;
    int           cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        nv = {32'h3333_0003, 32'hAAAA_0002, 32'h1234_5678, 32'h0000_0000};
        tv[0] = '{4'b0110, nv, 4'b0010, 2'd1, 1'b1, 1'b1, 32'h1234_5678};
        for (int i = 1; i <= 8; i++)
            tv[i] = '{4'b0110, nv, 4'b0010, 2'd1, 1'b1, 1'b0, 32'h1234_5678};
        tv[9] = '{4'b0110, nv, 4'b0100, 2'd2, 1'b1, 1'b1, 32'hAAAA_0002};

        // Idle with no requests keeps the display in reset
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        chk_reset_vals("idle_no_req");

        // Table: grant 1, dwell, hand over to 2
        for (int i = 0; i < 10; i++) begin
            req_i = tv[i].req;
            num_i = tv[i].num;
            tick();
            chk($sformatf("vec%0d", i),
                {24'h0, gnt_o, owner_o, busy_o, seg_rst_o, num_o},
                {24'h0, tv[i].gnt, tv[i].own, tv[i].busy, tv[i].srst,
                 tv[i].numo});
        end

        // Sole requester 3 with live value, no blank at expiry
        do_reset();
        req_i = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            held = $urandom;
            num_i[3*W +: W] = held;
            tick();
            chk("live_num", {32'h0, num_o}, {32'h0, held});
            if (i >= 1) chk("no_blank", {63'h0, seg_rst_o}, 64'h0);
        end

        // Owner 1 drops mid-dwell: grant cleared, value frozen, idle at expiry
        do_reset();
        req_i = 4'b0010;
        num_i = '0;
        num_i[W +: W] = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) tick();
        req_i = 4'b0000;
        num_i[W +: W] = 32'hDEAD_0002;
        tick();
        chk("drop_gnt", {60'h0, gnt_o}, 64'h0);
        chk("drop_frozen", {32'h0, num_o}, {32'h0, 32'hCAFE_0001});
        cnt = 5;
        while (busy_o && cnt < 30) begin
            tick();
            cnt++;
        end
        chk("idle_at_cycle", 64'(cnt), 64'd10);
        chk("idle_num", {32'h0, num_o}, {32'h0, 32'hCAFE_0001});
        chk("idle_srst", {63'h0, seg_rst_o}, 64'h0);

        // Async reset mid-hold
        do_reset();
        req_i = 4'b1000;
        num_i = {32'h0BAD_0003, 32'h2, 32'h1, 32'h600D_0000};
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        m_reset();
        @(negedge clk_i);
        rst = 1'b0;
        req_i = 4'b1111;
        tick();
        chk("after_rst_gnt", {60'h0, gnt_o}, 64'h1);
        chk("after_rst_num", {32'h0, num_o}, {32'h0, 32'h600D_0000});

`ifdef SEG7_ARB_PREEMPT_EN
        do_reset();
        req_i = 4'b0100;
        tick();
        for (int i = 0; i < 3; i++) tick();
        req_i = 4'b0101;
        tick();
        chk("preempt_gnt", {60'h0, gnt_o}, 64'h1);
        chk("preempt_srst", {63'h0, seg_rst_o}, 64'h1);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0)
                req_i = 4'($urandom) & 4'($urandom);
            num_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
